// File: rtl/max_pool_layer_if.sv
// Valid/ready stream carrying one packed multi-channel pixel per beat.
// The producer drives valid/data through master; the consumer drives ready through slave.
interface max_pool_layer_if #(
    parameter int DataWidth = 32
);
    logic                 valid;
    logic                 ready;
    logic [DataWidth-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/max_pool_layer.sv
// Non-overlapping PoolWidth x PoolWidth signed max-pooling over a raster-ordered feature map.
// Optional build macro POOL_RELU_EN clamps each input sample at zero ahead of the max.
module max_pool_layer #(
    parameter int LineWidthPx = 16,
    parameter int LineCountPx = 12,
    parameter int Channels    = 1,
    parameter int Width       = 32,
    parameter int PoolWidth   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    max_pool_layer_if.slave   upstream,
    max_pool_layer_if.master  downstream
);
    localparam int ColsOut = LineWidthPx / PoolWidth;
    localparam int XEnd    = ColsOut * PoolWidth;
    localparam int YEnd    = (LineCountPx / PoolWidth) * PoolWidth;
    localparam int XW      = $clog2(LineWidthPx);
    localparam int YW      = $clog2(LineCountPx);
    localparam int PW      = $clog2(PoolWidth);
    localparam int CW      = $clog2(ColsOut + 1);
    localparam int CIW     = (ColsOut > 1) ? $clog2(ColsOut) : 1;
    localparam int DW      = Channels * Width;

    logic [XW-1:0]  x_pos_reg;
    logic [YW-1:0]  y_pos_reg;
    logic [PW-1:0]  px_reg;
    logic [PW-1:0]  py_reg;
    logic [CW-1:0]  col_reg;
    logic [CIW-1:0] col_idx;

    logic ready;
    logic in_fire;
    logic in_window;
    logic last_px;
    logic last_py;
    logic row_end;
    logic col_write;
    logic produce;

    logic [DW-1:0] hmax_reg;
    logic [DW-1:0] h_next;
    logic [DW-1:0] v_next;
    logic [DW-1:0] colbuf_rd;
    logic [DW-1:0] colbuf_mem [ColsOut];

    logic          valid_reg;
    logic [DW-1:0] data_reg;

    function automatic logic signed [Width-1:0] smax(input logic signed [Width-1:0] a,
                                                     input logic signed [Width-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign ready   = ~valid_reg | downstream.ready;
    assign in_fire = upstream.valid & ready;

    assign last_px   = int'(px_reg) == PoolWidth - 1;
    assign last_py   = int'(py_reg) == PoolWidth - 1;
    assign row_end   = int'(x_pos_reg) == LineWidthPx - 1;
    assign in_window = (int'(x_pos_reg) < XEnd) && (int'(y_pos_reg) < YEnd);

    // col_reg only reaches ColsOut on trailing columns, which in_window excludes.
    assign col_idx   = col_reg[CIW-1:0];
    assign colbuf_rd = colbuf_mem[col_idx];

    assign col_write = in_fire & last_px & in_window & ~last_py;
    assign produce   = in_fire & last_px & in_window & last_py;

    genvar gi;
    generate
        for (gi = 0; gi < Channels; gi++) begin : g_ch
            logic signed [Width-1:0] s_raw;
            logic signed [Width-1:0] s;
            logic signed [Width-1:0] h;
            logic signed [Width-1:0] v;

            assign s_raw = upstream.data[gi*Width +: Width];
`ifdef POOL_RELU_EN
            assign s = s_raw[Width-1] ? '0 : s_raw;
`else
            assign s = s_raw;
`endif
            assign h = (px_reg == '0) ? s : smax(hmax_reg[gi*Width +: Width], s);
            // First row of a window overwrites, so stale buffer contents never leak.
            assign v = (py_reg == '0) ? h : smax(colbuf_rd[gi*Width +: Width], h);

            assign h_next[gi*Width +: Width] = h;
            assign v_next[gi*Width +: Width] = v;
        end
    endgenerate

    // Datapath storage needs no reset: px==0 and py==0 always overwrite it.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            hmax_reg <= h_next;
        end
        if (col_write) begin
            colbuf_mem[col_idx] <= v_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_pos_reg <= '0;
            y_pos_reg <= '0;
            px_reg    <= '0;
            py_reg    <= '0;
            col_reg   <= '0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            if (ready) begin
                valid_reg <= produce;
                if (produce) begin
                    data_reg <= v_next;
                end
            end

            if (in_fire) begin
                if (row_end) begin
                    x_pos_reg <= '0;
                    px_reg    <= '0;
                    col_reg   <= '0;
                    if (int'(y_pos_reg) == LineCountPx - 1) begin
                        y_pos_reg <= '0;
                        py_reg    <= '0;
                    end else begin
                        y_pos_reg <= y_pos_reg + 1'b1;
                        py_reg    <= last_py ? '0 : py_reg + 1'b1;
                    end
                end else begin
                    x_pos_reg <= x_pos_reg + 1'b1;
                    if (last_px) begin
                        px_reg  <= '0;
                        col_reg <= col_reg + 1'b1;
                    end else begin
                        px_reg  <= px_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign upstream.ready  = ready;
    assign downstream.valid = valid_reg;
    assign downstream.data  = data_reg;
endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench: 4x4/P=2, 5x5/P=2 trailing edges, backpressure, 9x6/P=3 2ch random, async reset.
module tb_max_pool_layer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    max_pool_layer_if #(.DataWidth(32)) a_up ();
    max_pool_layer_if #(.DataWidth(32)) a_dn ();
    max_pool_layer_if #(.DataWidth(32)) b_up ();
    max_pool_layer_if #(.DataWidth(32)) b_dn ();
    max_pool_layer_if #(.DataWidth(32)) c_up ();
    max_pool_layer_if #(.DataWidth(32)) c_dn ();

    max_pool_layer #(.LineWidthPx(4), .LineCountPx(4), .Channels(1), .Width(32), .PoolWidth(2))
        dut_a (.clk_i(clk), .rst_ni(rst_n), .upstream(a_up), .downstream(a_dn));
    max_pool_layer #(.LineWidthPx(5), .LineCountPx(5), .Channels(1), .Width(32), .PoolWidth(2))
        dut_b (.clk_i(clk), .rst_ni(rst_n), .upstream(b_up), .downstream(b_dn));
    max_pool_layer #(.LineWidthPx(9), .LineCountPx(6), .Channels(2), .Width(16), .PoolWidth(3))
        dut_c (.clk_i(clk), .rst_ni(rst_n), .upstream(c_up), .downstream(c_dn));

    logic [31:0] px_a [16];
    logic [31:0] ex_a [4];
    logic [31:0] ex_b [4];
    logic signed [15:0] frm [2][2][6][9];
    logic [31:0] exp_c [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams px_a through dut_a with ready_i=1; outputs fall on pixels 5,7,13,15.
    // stall_at >= 0 holds ready_i low for 10 cycles right after that pixel's output appears.
    task automatic run_a(input int stall_at);
        int oi;
        oi = 0;
        for (int k = 0; k < 16; k++) begin
            a_up.valid = 1'b1;
            a_up.data  = px_a[k];
            @(posedge clk); #1;
            if (k == 5 || k == 7 || k == 13 || k == 15) begin
                chk("a_valid", a_dn.valid, 1);
                chk("a_data", a_dn.data, ex_a[oi]);
                oi++;
            end else begin
                chk("a_idle", a_dn.valid, 0);
            end
            if (k == stall_at) begin
                a_dn.ready = 1'b0;
                a_up.data  = px_a[k+1];
                for (int s = 0; s < 10; s++) begin
                    @(posedge clk); #1;
                    chk("a_hold_valid", a_dn.valid, 1);
                    chk("a_hold_data", a_dn.data, ex_a[oi-1]);
                    chk("a_hold_ready", a_up.ready, 0);
                end
                a_dn.ready = 1'b1;
            end
        end
        a_up.valid = 1'b0;
    endtask

    initial begin
        int pix, got, bi, cyc, f, r;
        logic [31:0] e;
        logic signed [15:0] m, v;

        a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b1;
        b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b1;
        c_up.valid = 1'b0; c_up.data = '0; c_dn.ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_a_valid", a_dn.valid, 0);
        chk("rst_a_data", a_dn.data, 0);
        chk("rst_a_ready", a_up.ready, 1);
        chk("rst_b_valid", b_dn.valid, 0);
        chk("rst_c_valid", c_dn.valid, 0);
        chk("rst_c_data", c_dn.data, 0);

        // Ramp 0..15.
        for (int k = 0; k < 16; k++) px_a[k] = 32'(k);
        ex_a = '{32'd5, 32'd7, 32'd13, 32'd15};
        run_a(-1);

        // All -8 except (1,1) = -2.
        for (int k = 0; k < 16; k++) px_a[k] = 32'hFFFF_FFF8;
        px_a[5] = 32'hFFFF_FFFE;
`ifdef POOL_RELU_EN
        ex_a = '{32'd0, 32'd0, 32'd0, 32'd0};
`else
        ex_a = '{32'hFFFF_FFFE, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
`endif
        run_a(-1);

        // Backpressure after first output, ramp 20..35.
        for (int k = 0; k < 16; k++) px_a[k] = 32'(20 + k);
        ex_a = '{32'd25, 32'd27, 32'd33, 32'd35};
        run_a(5);

        // 5x5 frame, data = x + 10*y: trailing column 4 and row 4 produce nothing.
        ex_b = '{32'd11, 32'd13, 32'd31, 32'd33};
        bi = 0;
        for (int k = 0; k < 25; k++) begin
            b_up.valid = 1'b1;
            b_up.data  = 32'((k % 5) + 10 * (k / 5));
            @(posedge clk); #1;
            if (k == 6 || k == 8 || k == 16 || k == 18) begin
                chk("b_valid", b_dn.valid, 1);
                chk("b_data", b_dn.data, ex_b[bi]);
                bi++;
            end else begin
                chk("b_idle", b_dn.valid, 0);
            end
        end
        b_up.valid = 1'b0;

        // 9x6, 2 channels, P=3, two random frames with random valid/ready.
        for (int fi = 0; fi < 2; fi++)
            for (int ch = 0; ch < 2; ch++)
                for (int y = 0; y < 6; y++)
                    for (int x = 0; x < 9; x++)
                        frm[fi][ch][y][x] = 16'($urandom);
        for (int fi = 0; fi < 2; fi++)
            for (int wy = 0; wy < 2; wy++)
                for (int wx = 0; wx < 3; wx++) begin
                    for (int ch = 0; ch < 2; ch++) begin
                        m = 16'sh8000;
                        for (int dy = 0; dy < 3; dy++)
                            for (int dx = 0; dx < 3; dx++) begin
                                v = frm[fi][ch][wy*3+dy][wx*3+dx];
`ifdef POOL_RELU_EN
                                if (v < 0) v = 16'sd0;
`endif
                                if (v > m) m = v;
                            end
                        e[ch*16 +: 16] = m;
                    end
                    exp_c.push_back(e);
                end

        pix = 0; got = 0; cyc = 0;
        while ((pix < 108 || got < 12) && cyc < 4000) begin
            f = pix / 54;
            r = pix % 54;
            c_up.valid = (pix < 108) && ($urandom_range(0, 3) != 0);
            c_up.data  = (pix < 108) ? {frm[f][1][r/9][r%9], frm[f][0][r/9][r%9]} : 32'h0;
            c_dn.ready = $urandom_range(0, 2) != 0;
            @(negedge clk);
            if (c_dn.valid && c_dn.ready && got < 12) begin
                chk("c_data", c_dn.data, exp_c[got]);
                got++;
            end
            if (c_up.valid && c_up.ready) pix++;
            @(posedge clk); #1;
            cyc++;
        end
        c_up.valid = 1'b0;
        c_dn.ready = 1'b1;
        chk("c_pixels", 64'(pix), 108);
        chk("c_outputs", 64'(got), 12);
        @(posedge clk); #1;
        chk("c_drain", c_dn.valid, 0);

        // Reset mid-row after 6 samples, then a fresh frame.
        for (int k = 0; k < 16; k++) px_a[k] = 32'(k);
        for (int k = 0; k < 6; k++) begin
            a_up.valid = 1'b1;
            a_up.data  = px_a[k];
            @(posedge clk); #1;
        end
        a_up.valid = 1'b0;
        chk("pre_rst_valid", a_dn.valid, 1);
        chk("pre_rst_data", a_dn.data, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", a_dn.valid, 0);
        chk("async_rst_data", a_dn.data, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) px_a[k] = 32'(100 + k);
        ex_a = '{32'd105, 32'd107, 32'd113, 32'd115};
        run_a(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
